// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - ADC sample FIFO feeding an AXI-Stream FFT core with config handshake and frame tlast
// Optional build macro: FFT_FEEDER_DROP_CNT_EN enables the saturating dropped-sample counter.
module fft_frame_feeder #(
  parameter int          NFFT_LOG2 = 9,
  parameter int          FIFO_AW   = 4,
  parameter logic [15:0] CFG_WORD  = 16'h0109
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [13:0] sample_in,
  input  logic        sample_valid,
  output logic [15:0] s_axis_config_tdata,
  output logic        s_axis_config_tvalid,
  input  logic        s_axis_config_tready,
  output logic [31:0] s_axis_data_tdata,
  output logic        s_axis_data_tvalid,
  input  logic        s_axis_data_tready,
  output logic        s_axis_data_tlast,
  output logic        frame_done,
  output logic [15:0] drop_count
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic {S_CFG, S_STREAM} state_t;

  state_t state_q, state_d;
  logic   cfg_valid, stream_en;

  logic [13:0]          mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     count_q, count_d;
  // avail_q lags count_q by one cycle on writes so a new sample is presented
  // one edge after it lands in the FIFO.
  logic [FIFO_AW:0]     avail_q, avail_d;
  logic                 wr_lag_q;
  logic [NFFT_LOG2-1:0] beat_q;
  logic                 frame_done_q;

  logic full, pop, push;

  assign full = (count_q == (FIFO_AW+1)'(DEPTH));
  assign pop  = s_axis_data_tvalid && s_axis_data_tready;
  // A full FIFO still takes a sample when the head leaves on the same edge.
  assign push = sample_valid && (!full || pop);

  assign s_axis_config_tdata  = CFG_WORD;
  assign s_axis_config_tvalid = cfg_valid;
  assign s_axis_data_tvalid   = stream_en && (avail_q != '0);
  assign s_axis_data_tdata    = {18'd0, mem_q[rd_ptr_q]};
  assign s_axis_data_tlast    = s_axis_data_tvalid && (beat_q == '1);
  assign frame_done           = frame_done_q;

  // FSM state register
  always_ff @(posedge sclk) begin
    if (rst) state_q <= S_CFG;
    else     state_q <= state_d;
  end

  // FSM next state: leave CFG once the core takes the config word, never return
  always_comb begin
    state_d = state_q;
    if (state_q == S_CFG && s_axis_config_tready) state_d = S_STREAM;
  end

  // FSM outputs: config valid only in CFG, data path enabled only in STREAM
  always_comb begin
    cfg_valid = 1'b0;
    stream_en = 1'b0;
    case (state_q)
      S_CFG:    cfg_valid = 1'b1;
      S_STREAM: stream_en = 1'b1;
      default:  cfg_valid = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge sclk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= sample_in;
  end

  // Occupancy bookkeeping: true level and presentable level
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    avail_d = avail_q;
    if (wr_lag_q && !pop)      avail_d = avail_q + 1'b1;
    else if (pop && !wr_lag_q) avail_d = avail_q - 1'b1;
  end

  // FIFO pointers, levels, beat counter and frame-done pulse
  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      avail_q      <= '0;
      wr_lag_q     <= 1'b0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      avail_q      <= avail_d;
      wr_lag_q     <= push;
      frame_done_q <= pop && s_axis_data_tlast;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        beat_q   <= beat_q + 1'b1;
      end
    end
  end

`ifdef FFT_FEEDER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of samples lost to a full FIFO
  always_ff @(posedge sclk) begin
    if (rst)                                              drop_cnt_q <= '0;
    else if (sample_valid && !push && drop_cnt_q != '1)   drop_cnt_q <= drop_cnt_q + 1'b1;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - self-checking bench for fft_frame_feeder
module tb_fft_frame_feeder;
  localparam int N = 512;
  localparam int DEPTH = 16;

  logic        sclk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [15:0] s_axis_config_tdata;
  logic        s_axis_config_tvalid;
  logic        s_axis_config_tready = 1'b0;
  logic [31:0] s_axis_data_tdata;
  logic        s_axis_data_tvalid;
  logic        s_axis_data_tready = 1'b0;
  logic        s_axis_data_tlast;
  logic        frame_done;
  logic [15:0] drop_count;

  always #5 sclk = ~sclk;

  fft_frame_feeder dut (
    .sclk                 (sclk),
    .rst                  (rst),
    .sample_in            (sample_in),
    .sample_valid         (sample_valid),
    .s_axis_config_tdata  (s_axis_config_tdata),
    .s_axis_config_tvalid (s_axis_config_tvalid),
    .s_axis_config_tready (s_axis_config_tready),
    .s_axis_data_tdata    (s_axis_data_tdata),
    .s_axis_data_tvalid   (s_axis_data_tvalid),
    .s_axis_data_tready   (s_axis_data_tready),
    .s_axis_data_tlast    (s_axis_data_tlast),
    .frame_done           (frame_done),
    .drop_count           (drop_count)
  );

  int total = 0;
  int bad = 0;

  // Reference model: a queue of samples, each tagged with the edge at which it was written.
  typedef struct { logic [13:0] d; int w; } ent_t;
  ent_t mq[$];
  bit   m_stream = 1'b0;
  bit   m_fd = 1'b0;
  int   m_beat = 0;
  int   m_drops = 0;
  int   cyc = 0;

  // Observed-beat bookkeeping from the DUT side
  int          beats_seen = 0;
  int          fd_seen = 0;
  int          last_idx[$];
  logic [13:0] last_data = '0;

  typedef struct {
    bit r; bit v; logic [13:0] s; bit c; bit d;
    bit e_cfg; bit e_dv; bit e_last; logic [13:0] e_data;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_drop(input int n);
    logic [15:0] r;
    r = (n > 65535) ? 16'hFFFF : 16'(n);
`ifndef FFT_FEEDER_DROP_CNT_EN
    r = 16'd0;
`endif
    return r;
  endfunction

  // A sample written at edge k may be presented only once edge k+1 has passed.
  function automatic bit m_dv();
    return m_stream && (mq.size() > 0) && (mq[0].w < cyc);
  endfunction

  task automatic step(input bit r, input bit v, input logic [13:0] s, input bit c, input bit d);
    bit mdv, mlast, pop, push;
    rst = r; sample_valid = v; sample_in = s;
    s_axis_config_tready = c; s_axis_data_tready = d;
    if (s_axis_data_tvalid === 1'b1 && d) begin
      if (s_axis_data_tlast === 1'b1) last_idx.push_back(beats_seen);
      last_data = s_axis_data_tdata[13:0];
      beats_seen++;
    end
    cyc++;
    if (r) begin
      m_stream = 1'b0; mq.delete(); m_beat = 0; m_drops = 0; m_fd = 1'b0;
    end else begin
      mdv   = m_stream && (mq.size() > 0) && (mq[0].w < cyc - 1);
      pop   = mdv && d;
      mlast = mdv && (m_beat == N - 1);
      m_fd  = pop && mlast;
      if (!m_stream && c) m_stream = 1'b1;
      push = v && ((mq.size() < DEPTH) || pop);
      if (pop) begin
        mq.delete(0);
        m_beat = (m_beat + 1) % N;
      end
      if (push) mq.push_back(ent_t'{d: s, w: cyc});
      else if (v) m_drops++;
    end
    @(posedge sclk);
    @(negedge sclk);
    if (frame_done === 1'b1) fd_seen++;
    mdv = m_dv();
    chk("cfg_tvalid", 32'(s_axis_config_tvalid), 32'(!m_stream));
    if (!m_stream) chk("cfg_tdata", 32'(s_axis_config_tdata), 32'h0109);
    chk("data_tvalid", 32'(s_axis_data_tvalid), 32'(mdv));
    if (mdv) begin
      chk("data_tdata", s_axis_data_tdata, {18'd0, mq[0].d});
      chk("data_tlast", 32'(s_axis_data_tlast), 32'(m_beat == N - 1));
    end else begin
      chk("data_tlast_idle", 32'(s_axis_data_tlast), 32'd0);
    end
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("drop_count", 32'(drop_count), 32'(exp_drop(m_drops)));
  endtask

  task automatic reset_and_config();
    step(1, 0, 14'd0, 0, 0);
    step(0, 0, 14'd0, 1, 0);
  endtask

  initial begin
    // inputs: r v s c d | expected after edge: cfg dv last data
    tbl[0] = '{1, 1, 14'h3FFF, 0, 0, 1, 0, 0, 14'h0};
    tbl[1] = '{0, 0, 14'h0,    0, 0, 1, 0, 0, 14'h0};
    tbl[2] = '{0, 0, 14'h0,    0, 0, 1, 0, 0, 14'h0};
    tbl[3] = '{0, 0, 14'h0,    1, 0, 0, 0, 0, 14'h0};
    tbl[4] = '{0, 1, 14'h1234, 0, 0, 0, 0, 0, 14'h0};
    tbl[5] = '{0, 0, 14'h0,    0, 0, 0, 1, 0, 14'h1234};
    tbl[6] = '{0, 0, 14'h0,    0, 0, 0, 1, 0, 14'h1234};
    tbl[7] = '{0, 0, 14'h0,    0, 1, 0, 0, 0, 14'h0};

    @(negedge sclk);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_cfg", i), 32'(s_axis_config_tvalid), 32'(tbl[i].e_cfg));
      chk($sformatf("tbl%0d_dv", i), 32'(s_axis_data_tvalid), 32'(tbl[i].e_dv));
      chk($sformatf("tbl%0d_last", i), 32'(s_axis_data_tlast), 32'(tbl[i].e_last));
      if (tbl[i].e_dv) chk($sformatf("tbl%0d_data", i), s_axis_data_tdata, {18'd0, tbl[i].e_data});
    end

    // Two full frames, continuous samples, sink always ready
    reset_and_config();
    beats_seen = 0; fd_seen = 0; last_idx.delete();
    for (int i = 0; i < 1024; i++) step(0, 1, 14'(i), 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 14'd0, 0, 1);
    chk("two_frames_beats", 32'(beats_seen), 32'd1024);
    chk("two_frames_tlast_cnt", 32'(last_idx.size()), 32'd2);
    if (last_idx.size() == 2) begin
      chk("two_frames_tlast0", 32'(last_idx[0]), 32'd511);
      chk("two_frames_tlast1", 32'(last_idx[1]), 32'd1023);
    end
    chk("two_frames_done", 32'(fd_seen), 32'd2);
    chk("two_frames_last_data", 32'(last_data), 32'd1023);

    // Full FIFO: a write with a simultaneous pop is accepted
    reset_and_config();
    for (int i = 0; i < 16; i++) step(0, 1, 14'(i), 0, 0);
    step(0, 1, 14'd16, 0, 0);
    chk("full_drop", 32'(drop_count), 32'(exp_drop(1)));
    step(0, 1, 14'd17, 0, 1);
    chk("full_push_pop_nodrop", 32'(drop_count), 32'(exp_drop(1)));
    beats_seen = 0;
    for (int i = 0; i < 20; i++) step(0, 0, 14'd0, 0, 1);
    chk("full_level_drain", 32'(beats_seen), 32'd16);
    chk("full_last_data", 32'(last_data), 32'd17);

    // Sink ready every other cycle while samples arrive every cycle
    reset_and_config();
    beats_seen = 0;
    for (int i = 0; i < 100; i++) step(0, 1, 14'(i), 0, bit'(i % 2));
    for (int i = 0; i < 40; i++) step(0, 0, 14'd0, 0, 1);
    chk("toggle_drops", 32'(drop_count), 32'(exp_drop(100 - beats_seen)));

    // Reset in the middle of a frame, then a fresh frame from beat 0
    reset_and_config();
    beats_seen = 0;
    for (int i = 0; i < 300 && beats_seen < 201; i++) step(0, 1, 14'(i), 0, 1);
    chk("midframe_reached", 32'(beats_seen >= 201), 32'd1);
    step(1, 1, 14'd5, 0, 1);
    chk("midframe_rst_tvalid", 32'(s_axis_data_tvalid), 32'd0);
    chk("midframe_rst_cfg", 32'(s_axis_config_tvalid), 32'd1);
    step(0, 0, 14'd0, 1, 1);
    beats_seen = 0; last_idx.delete();
    for (int i = 0; i < 520; i++) step(0, 1, 14'(i), 0, 1);
    chk("midframe_tlast_seen", 32'(last_idx.size() > 0), 32'd1);
    if (last_idx.size() > 0) chk("midframe_tlast_idx", 32'(last_idx[0]), 32'd511);

    // Random traffic against the model, with rare resets
    reset_and_config();
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 499) == 0), bit'($urandom_range(0, 3) != 0),
           14'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_frame_feeder.md
FFT_FRAME_FEEDER -- requirements
Module: fft_frame_feeder

Interface
REQ-001 SHALL have parameter NFFT_LOG2, default 9, log2 of frame length N (N = 512).
REQ-002 SHALL have parameter FIFO_AW, default 4, FIFO address width (depth 2**FIFO_AW = 16).
REQ-003 SHALL have parameter CFG_WORD, default 16'h0109, the FFT config word (FWD, CP_LEN, NFFT=9).
REQ-004 SHALL have port sclk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sample_in  input  14  ADC sample, unsigned.
REQ-007 SHALL have port sample_valid  input  1  sample_in is valid this cycle.
REQ-008 SHALL have port s_axis_config_tdata  output  16  config word to FFT core.
REQ-009 SHALL have port s_axis_config_tvalid  output  1  config word valid.
REQ-010 SHALL have port s_axis_config_tready  input  1  FFT core accepts config.
REQ-011 SHALL have port s_axis_data_tdata  output  32  {18'd0, sample}: real in [13:0], imag zero.
REQ-012 SHALL have port s_axis_data_tvalid  output  1  data beat valid.
REQ-013 SHALL have port s_axis_data_tready  input  1  FFT core accepts data.
REQ-014 SHALL have port s_axis_data_tlast  output  1  last beat of an N-sample frame.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the tlast beat transfers.
REQ-016 SHALL have port drop_count  output  16  samples dropped on FIFO full (see REQ-035).

Function
REQ-017 SHALL implement FSM states CFG and STREAM; reset enters CFG.
REQ-018 In CFG SHALL drive s_axis_config_tvalid=1, tdata=CFG_WORD; on tvalid&tready go to STREAM next cycle, tvalid=0.
REQ-019 s_axis_config_tvalid SHALL stay 0 in STREAM; CFG is never re-entered except by reset.
REQ-020 SHALL write sample_in to FIFO when sample_valid=1 and FIFO not full, in both states.
REQ-021 When FIFO full, write SHALL still be accepted if a pop occurs the same cycle.
REQ-022 SHALL drop sample_valid samples when full and no simultaneous pop; FIFO contents unchanged.
REQ-023 s_axis_data_tvalid SHALL be 0 in CFG; in STREAM it is 1 whenever FIFO is non-empty.
REQ-024 Latency: sample written at edge t into an empty FIFO in STREAM SHALL appear on tdata with tvalid=1 after edge t+1.
REQ-025 Once tvalid=1, tdata and tlast SHALL hold stable until tvalid&tready.
REQ-026 Pop SHALL occur only on tvalid&tready; no pop when empty.
REQ-027 Beat counter (NFFT_LOG2 bits) SHALL increment per transferred beat, wrapping N-1 -> 0.
REQ-028 s_axis_data_tlast SHALL be 1 exactly when tvalid=1 and beat counter = N-1.
REQ-029 frame_done SHALL pulse for one cycle on the edge after the tlast beat transfers.
REQ-030 Stalls (tready=0) SHALL not alter beat counter, tdata or tlast.

Reset
REQ-031 On rst=1 at a rising edge: FSM=CFG, FIFO flushed (empty), beat counter=0, drop_count=0.
REQ-032 During and after reset: s_axis_data_tvalid=0, tlast=0, frame_done=0, config tvalid=1 on first post-reset cycle.
REQ-033 Reset mid-frame SHALL discard the partial frame; next frame starts at beat 0 after re-config.
REQ-034 sample_valid asserted while rst=1 SHALL be ignored.

Configuration
REQ-035 With macro FFT_FEEDER_DROP_CNT_EN defined, drop_count SHALL count dropped samples (REQ-022), saturating at 16'hFFFF, cleared only by reset.
REQ-036 Without FFT_FEEDER_DROP_CNT_EN, drop_count SHALL be tied to 16'd0 and no counter logic SHALL be built.

Verification
REQ-037 Reset, config tready=1 at cycle 3 -> config tvalid high cycles 1-3 with data 16'h0109, low thereafter, FSM in STREAM.
REQ-038 Continuous samples 0..1023, data tready=1 -> 1024 beats in order, tlast on beats 511 and 1023, two frame_done pulses, drop_count=0.
REQ-039 tready toggles 1/0 each cycle, samples every cycle -> FIFO fills, drops occur; with macro drop_count = samples sent minus beats delivered; beats remain ordered, tdata stable while stalled.
REQ-040 Full FIFO (16 entries), sample_valid with tready=1 same cycle -> write accepted, no drop, level stays 16.
REQ-041 rst asserted after beat 200 -> tvalid low next cycle, FIFO empty, re-config, next tlast on the 512th post-config beat.
